// File: rtl/nn_pkg.sv
// Shared constants, types and frame index boundaries for the 4-4-2 node input loader.
package nn_pkg;

    localparam int DATA_W      = 5;
    localparam int N_WORDS     = 28;
    localparam int HOLD_CYCLES = 3;
    localparam int IDX_W       = $clog2(N_WORDS);
    localparam int HOLD_W      = $clog2(HOLD_CYCLES + 1);

    // Last index of each frame section: activations, layer-1 weights, layer-2 weights.
    localparam int X_LAST  = 3;
    localparam int W1_LAST = 19;
    localparam int W2_LAST = 27;

    typedef logic [DATA_W-1:0] nn_word_t;
    typedef logic [IDX_W-1:0]  nn_idx_t;
    typedef logic [HOLD_W-1:0] nn_hold_t;

    typedef enum logic [1:0] {IDLE, LOAD, FIRE} loader_state_t;

endpackage

// File: rtl/nn_word_bank.sv
// 28-entry addressed operand register file with a flat parallel read-out.
module nn_word_bank
    import nn_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we_i,
    input  nn_idx_t                   idx_i,
    input  nn_word_t                  wdata_i,
    output logic [N_WORDS*DATA_W-1:0] bank_o
);

    nn_word_t mem_q [N_WORDS];

    // NOTE: every entry is reset because the operands drive the node directly and must read 0 after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_WORDS; i++) mem_q[i] <= '0;
        end else if (we_i && (int'(idx_i) < N_WORDS)) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    for (genvar g = 0; g < N_WORDS; g++) begin : g_flat
        assign bank_o[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/nn_input_loader.sv
// Serial-to-parallel operand loader for the 4-4-2 node; fires in_ready for HOLD_CYCLES per frame.
// Optional macro NN_INPUT_LOADER_WEIGHT_PERSIST_EN allows 4-word activation-only frames once weights are loaded.
module nn_input_loader
    import nn_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     s_valid,
    input  nn_word_t s_data,
    input  logic     s_last,
    output logic     s_ready,
    output nn_word_t x0, x1, x2, x3,
    output nn_word_t w04, w05, w06, w07,
    output nn_word_t w14, w15, w16, w17,
    output nn_word_t w24, w25, w26, w27,
    output nn_word_t w34, w35, w36, w37,
    output nn_word_t w48, w58, w68, w78,
    output nn_word_t w49, w59, w69, w79,
    output logic     in_ready,
    output logic     busy,
    output logic     err_len
);

    loader_state_t state_q, state_d;
    nn_idx_t       idx_q, idx_d;
    nn_hold_t      hold_q, hold_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          xfer;
    logic          at_end;
    logic          short_ok;
    logic [N_WORDS*DATA_W-1:0] bank;

    assign s_ready = (state_q != FIRE);
    assign xfer    = s_valid && s_ready;
    assign at_end  = (idx_q == IDX_W'(W2_LAST));

`ifdef NN_INPUT_LOADER_WEIGHT_PERSIST_EN
    logic weights_loaded_q, weights_loaded_d;
    assign short_ok = weights_loaded_q && (idx_q == IDX_W'(X_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) weights_loaded_q <= 1'b0;
        else     weights_loaded_q <= weights_loaded_d;
    end

    assign weights_loaded_d = weights_loaded_q || (xfer && s_last && at_end);
`else
    assign short_ok = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hold_d     = hold_q;
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (xfer) begin
                    if (s_last && (at_end || short_ok)) begin
                        state_d    = FIRE;
                        idx_d      = '0;
                        hold_d     = HOLD_W'(HOLD_CYCLES - 1);
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end else if (s_last || at_end) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = LOAD;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            FIRE: begin
                if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d     = hold_q - 1'b1;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            hold_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_q     <= hold_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign err_len  = err_q;

    nn_word_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (xfer),
        .idx_i   (idx_q),
        .wdata_i (s_data),
        .bank_o  (bank)
    );

    assign {w79, w69, w59, w49, w78, w68, w58, w48,
            w37, w36, w35, w34, w27, w26, w25, w24,
            w17, w16, w15, w14, w07, w06, w05, w04,
            x3,  x2,  x1,  x0} = bank;

endmodule
